// File: rtl/eem16_sym_encoder_pkg.sv
// eem16_sym_encoder_pkg: shared constants for the button-to-symbol encoder
package eem16_sym_encoder_pkg;
    localparam int   DEBOUNCE_CYCLES_DEFAULT = 4;
    localparam logic SYM_ZERO                = 1'b0;
    localparam logic SYM_ONE                 = 1'b1;
    localparam int   FIFO_DEPTH              = 2;
endpackage

// File: rtl/eem16_btn_debounce.sv
// eem16_btn_debounce: 2-flop synchronizer, counting debouncer and press (0->1) pulse
module eem16_btn_debounce
    import eem16_sym_encoder_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic press
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    logic [1:0]    sync;
    logic          level;
    logic          prev_level;
    logic [CW-1:0] cnt;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync       <= '0;
            level      <= 1'b0;
            prev_level <= 1'b0;
            cnt        <= '0;
        end else begin
            sync       <= {sync[0], btn};
            prev_level <= level;
            if (sync[1] == level)
                cnt <= '0;
            else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                // this sample is the DEBOUNCE_CYCLES-th consecutive one at the new level
                level <= ~level;
                cnt   <= '0;
            end else
                cnt <= cnt + 1'b1;
        end
    end
    assign press = level & ~prev_level;
endmodule

// File: rtl/eem16_sym_encoder.sv
// eem16_sym_encoder: two debounced buttons feeding a 2-entry symbol FIFO and registered x0/x1 strobe
module eem16_sym_encoder
    import eem16_sym_encoder_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_zero,
    input  logic btn_one,
    input  logic hold,
    output logic x1,
    output logic x0,
    output logic overflow
);
    logic                  press_zero;
    logic                  press_one;
    logic [FIFO_DEPTH-1:0] mem;
    logic                  rd_ptr;
    logic                  wr_ptr;
    logic [1:0]            count;
    logic                  pop;
    logic [1:0]            n_ev;
    logic [1:0]            free;
    logic [1:0]            n_acc;
    logic                  first_sym;

    eem16_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_zero (
        .clk(clk), .reset(reset), .btn(btn_zero), .press(press_zero)
    );
    eem16_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_one (
        .clk(clk), .reset(reset), .btn(btn_one), .press(press_one)
    );

    // pop frees its slot before pushes; symbol 0 takes the first free slot
    always_comb begin
        pop       = (count != 2'd0) && !hold;
        n_ev      = {1'b0, press_zero} + {1'b0, press_one};
        free      = 2'(FIFO_DEPTH) - count + {1'b0, pop};
        n_acc     = (n_ev < free) ? n_ev : free;
        first_sym = press_zero ? SYM_ZERO : SYM_ONE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem      <= '0;
            rd_ptr   <= 1'b0;
            wr_ptr   <= 1'b0;
            count    <= 2'd0;
            x0       <= 1'b0;
            x1       <= 1'b0;
            overflow <= 1'b0;
        end else begin
            x0     <= pop;
            x1     <= pop & mem[rd_ptr];
            rd_ptr <= rd_ptr ^ pop;
            wr_ptr <= wr_ptr ^ n_acc[0];
            count  <= count - {1'b0, pop} + n_acc;
            if (n_acc != 2'd0)
                mem[wr_ptr] <= first_sym;
            if (n_acc == 2'd2)
                mem[~wr_ptr] <= SYM_ONE;
            if (n_ev > n_acc)
                overflow <= 1'b1;
        end
    end
endmodule

// File: tb/tb_eem16_sym_encoder.sv
// tb_eem16_sym_encoder: table-driven, hand-timed and random checks of the symbol encoder
module tb_eem16_sym_encoder;
    localparam int N = 400;
    localparam int NROWS = 17;

    typedef struct {
        logic b0, b1, h;
        int   n, strobes, ones, first;
        logic ovf;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic btn_zero = 1'b0;
    logic btn_one = 1'b0;
    logic hold = 1'b0;
    logic x1, x0, overflow;
    int   tests = 0;
    int   fails = 0;

    vec_t tbl [NROWS];
    bit   raw [2][N];
    bit   ev  [2][N];
    bit   hb  [N];
    bit   q   [$];
    bit   hcur;
    logic ex0, ex1, eov;
    int   s, o, f, t, g, h;

    eem16_sym_encoder #(.DEBOUNCE_CYCLES(4)) dut (
        .clk(clk), .reset(reset), .btn_zero(btn_zero), .btn_one(btn_one),
        .hold(hold), .x1(x1), .x0(x0), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input logic b0, input logic b1, input logic hh);
        btn_zero = b0;
        btn_one  = b1;
        hold     = hh;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        btn_zero = 1'b0;
        btn_one  = 1'b0;
        hold     = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        tbl[0]  = '{1'b0, 1'b0, 1'b0, 20, 0, 0, 0, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 1'b0, 12, 1, 1, 1, 1'b0};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 12, 0, 0, 0, 1'b0};
        tbl[3]  = '{1'b1, 1'b0, 1'b0,  3, 0, 0, 0, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 10, 0, 0, 0, 1'b0};
        tbl[5]  = '{1'b1, 1'b0, 1'b0,  1, 0, 0, 0, 1'b0};
        tbl[6]  = '{1'b0, 1'b0, 1'b0,  1, 0, 0, 0, 1'b0};
        tbl[7]  = '{1'b1, 1'b0, 1'b0, 12, 1, 0, 0, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 12, 0, 0, 0, 1'b0};
        tbl[9]  = '{1'b1, 1'b1, 1'b0, 12, 2, 1, 0, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 12, 0, 0, 0, 1'b0};
        tbl[11] = '{1'b1, 1'b0, 1'b1, 10, 0, 0, 0, 1'b0};
        tbl[12] = '{1'b0, 1'b0, 1'b1, 10, 0, 0, 0, 1'b0};
        tbl[13] = '{1'b0, 1'b1, 1'b1, 10, 0, 0, 0, 1'b0};
        tbl[14] = '{1'b0, 1'b0, 1'b1, 10, 0, 0, 0, 1'b0};
        tbl[15] = '{1'b1, 1'b0, 1'b1, 10, 0, 0, 0, 1'b1};
        tbl[16] = '{1'b0, 1'b0, 1'b0,  6, 2, 1, 0, 1'b1};

        do_reset();
        for (int r = 0; r < NROWS; r++) begin
            s = 0;
            o = 0;
            f = -1;
            for (int c = 0; c < tbl[r].n; c++) begin
                step(tbl[r].b0, tbl[r].b1, tbl[r].h);
                if (x0) begin
                    if (f < 0) f = int'(x1);
                    s++;
                    o += int'(x1);
                end
            end
            chk($sformatf("row%0d strobes", r), s, tbl[r].strobes);
            chk($sformatf("row%0d ones", r), o, tbl[r].ones);
            chk($sformatf("row%0d overflow", r), int'(overflow), int'(tbl[r].ovf));
            if (tbl[r].strobes > 0)
                chk($sformatf("row%0d first_x1", r), f, tbl[r].first);
        end

        // clean btn_one press first sampled at edge 10 strobes after edge 17
        do_reset();
        chk("reset x0x1ovf", int'({x0, x1, overflow}), 0);
        for (int i = 0; i <= 22; i++) begin
            step(1'b0, i >= 10 && i < 20, 1'b0);
            chk($sformatf("latency x0@%0d", i), int'(x0), int'(i == 17));
            chk($sformatf("latency x1@%0d", i), int'(x1), int'(i == 17));
        end

        // simultaneous presses: symbol 0 then symbol 1 on consecutive cycles
        do_reset();
        for (int i = 0; i <= 21; i++) begin
            step(i >= 10, i >= 10, 1'b0);
            chk($sformatf("both x0@%0d", i), int'(x0), int'(i == 17 || i == 18));
            chk($sformatf("both x1@%0d", i), int'(x1), int'(i == 18));
        end
        chk("both overflow", int'(overflow), 0);

        // async reset with one symbol still buffered and btn_zero held through it
        do_reset();
        for (int i = 0; i <= 7; i++) step(1'b1, 1'b1, 1'b0);
        chk("pre-reset x0", int'(x0), 1);
        chk("pre-reset x1", int'(x1), 0);
        #1;
        reset   = 1'b1;
        btn_one = 1'b0;
        #1;
        chk("async reset x0", int'(x0), 0);
        chk("async reset x1", int'(x1), 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i <= 15; i++) begin
            step(1'b1, 1'b0, 1'b0);
            chk($sformatf("held x0@%0d", i), int'(x0), int'(i == 7));
            chk($sformatf("held x1@%0d", i), int'(x1), 0);
        end
        chk("held overflow", int'(overflow), 0);

        // random clean presses and short glitches against an event-level queue model
        for (int b = 0; b < 2; b++) begin
            t = int'($urandom_range(0, 10));
            while (t < N - 40) begin
                if ($urandom_range(0, 3) == 0) begin
                    g = int'($urandom_range(1, 3));
                    for (int j = 0; j < g; j++) raw[b][t + j] = 1'b1;
                    t += g + int'($urandom_range(3, 8));
                end else begin
                    h = int'($urandom_range(6, 12));
                    for (int j = 0; j < h; j++) raw[b][t + j] = 1'b1;
                    ev[b][t + 6] = 1'b1;
                    t += h + int'($urandom_range(6, 12));
                end
            end
        end
        hcur = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (i % 8 == 0) hcur = ($urandom_range(0, 3) == 0);
            hb[i] = (i >= N / 2) && (i < N - 20) && hcur;
        end
        do_reset();
        eov = 1'b0;
        q.delete();
        for (int i = 0; i < N; i++) begin
            step(raw[0][i], raw[1][i], hb[i]);
            ex0 = (q.size() > 0) && !hb[i];
            ex1 = 1'b0;
            if (ex0) ex1 = q.pop_front();
            for (int b = 0; b < 2; b++)
                if (ev[b][i]) begin
                    if (q.size() < 2) q.push_back(b == 1);
                    else eov = 1'b1;
                end
            chk($sformatf("rand@%0d {x0,x1,ovf}", i), int'({x0, x1, overflow}), int'({ex0, ex1, eov}));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/eem16_sym_encoder.md
# eem16_sym_encoder

Input-conditioning stage that feeds the two-flip-flop sequence recognizer. Two raw push-button inputs are synchronized, debounced and edge-detected. Each accepted press becomes a one-cycle symbol on the recognizer's input pair: x0 is the valid strobe and x1 is the symbol bit. A two-entry buffer sits in front of the output register, so simultaneous presses and presses made while output is held are not lost.

## Interface
- DEBOUNCE_CYCLES, 4: consecutive synchronized samples at the new level required before the debounced level changes. Legal range 2..65535; the bench uses 4 and the board build uses 250000/..., capped to 65535.
- clk  input  1  single system clock, rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- btn_zero  input  1  raw, asynchronous button; a press emits symbol 0.
- btn_one  input  1  raw, asynchronous button; a press emits symbol 1.
- hold  input  1  when high, no strobe is issued and buffered symbols are retained.
- x1  output  1  symbol bit; meaningful only while x0=1, and 0 otherwise.
- x0  output  1  one-cycle symbol-valid strobe.
- overflow  output  1  sticky; set when a press is dropped, cleared only by reset.

## Operation
- Per button, a 2-flop synchronizer feeds a debouncer.
  - The debouncer keeps a level register plus a counter of width clog2(DEBOUNCE_CYCLES+1).
  - The counter increments while the synchronized sample differs from the level and clears to 0 whenever they match.
  - When the count reaches DEBOUNCE_CYCLES, the level toggles and the counter clears.
- A press event is a 0→1 transition of the debounced level. Release (1→0) produces no event.
- Events push into a 2-entry FIFO of symbol bits.
- When both channels fire in the same cycle, symbol 0 is pushed before symbol 1.
- FIFO pop: when the FIFO is non-empty and hold=0, pop one entry per cycle into the output register (x0=1, x1=entry). In every other cycle, x0=0 and x1=0.
- A push and a pop may occur in the same cycle. The pop is taken first, so a full FIFO with hold=0 accepts one new event.
- Push to a full FIFO: the event is dropped and overflow is set.
  - Two simultaneous events with one free slot: symbol 0 is kept, symbol 1 is dropped, and overflow is set.
- Reset (asynchronous, any time):
  - synchronizers, levels, counters, FIFO pointers and count, x0, x1 and overflow all go to 0;
  - pending symbols are discarded.
- A button held through reset release is treated as a fresh press and produces exactly one event after debounce.

## Timing
- Reset values: x0=0, x1=0, overflow=0.
- Latency: let edge k be the first rising edge at which a raw button is sampled high (empty FIFO, hold=0, input stable). Then:
  - the debounced level toggles at edge k+DEBOUNCE_CYCLES+1;
  - the event pushes at edge k+DEBOUNCE_CYCLES+2;
  - x0 is high for exactly one cycle after edge k+DEBOUNCE_CYCLES+3.
  - With DEBOUNCE_CYCLES=4, x0 is high after edge k+7.
- A glitch shorter than DEBOUNCE_CYCLES synchronized samples produces no event and leaves the counter at 0 afterwards.
- Back-to-back strobes are allowed. The downstream FSM consumes one symbol per cycle, so there is no ready signal.
- hold is sampled at the same edge as the pop. hold rising blocks the strobe for the next cycle; hold falling releases the head entry on the next cycle.
- All outputs are registered, with no combinational path from any input to any output.

## Structure
- Shared package/header:
  - the DEBOUNCE_CYCLES default;
  - symbol encodings SYM_ZERO=1'b0 and SYM_ONE=1'b1;
  - the FIFO depth constant (2).
- Sub-module eem16_btn_debounce (synchronizer + counter + level + rise pulse), instantiated twice.
- The top level holds the FIFO, the pop/output register and the overflow flag.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4.
- Reset then idle 20 cycles → x0=0, x1=0, overflow=0 throughout.
- Clean btn_one press sampled at edge 10 → single x0=1, x1=1 after edge 17. Release → no strobe.
- btn_zero glitch high for 3 cycles → no strobe, overflow=0. Then a bounce of 1-0-1 followed by steady high → exactly one x0 with x1=0.
- Both buttons pressed at the same edge → strobes on consecutive cycles, x1=0 then x1=1; overflow=0.
- hold=1 with three presses (0, 1, 0) → no strobes and overflow=1 (third press dropped). Then hold=0 → strobes with x1=0 then x1=1 on consecutive cycles.
- Reset asserted mid-debounce and with one symbol buffered → outputs 0 immediately, buffered symbol never emitted. Button still held at reset release → one strobe 7 edges after release.
